// File: rtl/fetch_pipe.sv
// rtl/fetch_pipe.sv - buffered Y86-64 fetch stage: aligned beats into a byte queue, split into instructions
// Optional FETCH_PREDICT_EN: predict-taken redirect on icode 7/8 transfers.
module fetch_pipe #(
  parameter int          FETCH_BYTES = 8,
  parameter int          QUEUE_BYTES = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [63:0]              redirect_pc_i,
  output logic                     imem_req_o,
  output logic [63:0]              imem_addr_o,
  input  logic                     imem_ready_i,
  input  logic                     imem_rvalid_i,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata_i,
  input  logic                     imem_err_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              pc_o,
  output logic [63:0]              valC_o,
  output logic [63:0]              valP_o,
  output logic [3:0]               icode_o,
  output logic [3:0]               ifun_o,
  output logic [3:0]               rA_o,
  output logic [3:0]               rB_o,
  output logic                     instr_valid_o,
  output logic                     imem_error_o
);
  localparam int PW = $clog2(QUEUE_BYTES);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(FETCH_BYTES);
  localparam logic [63:0] ALIGN_MASK = ~64'(FETCH_BYTES - 1);

  logic [7:0]    q_q [QUEUE_BYTES];
  logic [7:0]    q_d [QUEUE_BYTES];
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   pc_q, pc_d, faddr_q, faddr_d;
  logic          outst_q, outst_d, stale_q, stale_d, skip_q, skip_d;
  logic [OW-1:0] skip_off_q, skip_off_d;
  logic          stop_q, stop_d, err_pend_q, err_pend_d;

  logic [7:0]    hb [10];
  logic [3:0]    icode, len;
  logic [63:0]   valc_dec, valp_dec, new_pc;
  logic          has_regs, have, err_slot, valid, xfer, pred_redir, flush;
  logic          accept, resp, take_beat, err_beat;
  logic [OW-1:0] off_eff;
  logic [PW-1:0] tail, widx;

  always_comb begin
    for (int i = 0; i < 10; i++) hb[i] = q_q[head_q + PW'(i)];
    icode = hb[0][7:4];
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
      4'h7, 4'h8:             len = 4'd9;
      4'h3, 4'h4, 4'h5:       len = 4'd10;
      default:                len = 4'd1;
    endcase
    has_regs = (len == 4'd2) || (len == 4'd10);
    case (icode)
      4'h3, 4'h4, 4'h5: valc_dec = {hb[9], hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2]};
      4'h7, 4'h8:       valc_dec = {hb[8], hb[7], hb[6], hb[5], hb[4], hb[3], hb[2], hb[1]};
      default:          valc_dec = 64'h0;
    endcase
    have = count_q >= CW'(len);
    // A faulted fetch surfaces only once nothing complete is left ahead of it.
    err_slot = err_pend_q && !have;
    valid    = !stop_q && (have || err_slot);
    valp_dec = err_slot ? pc_q : pc_q + 64'(len);
    xfer     = valid && out_ready_i && !redirect_i;
`ifdef FETCH_PREDICT_EN
    pred_redir = xfer && !err_slot && (icode == 4'h7 || icode == 4'h8);
`else
    pred_redir = 1'b0;
`endif
    flush  = redirect_i || pred_redir;
    new_pc = redirect_i ? redirect_pc_i : valc_dec;
  end

  always_comb begin
    out_valid_o   = valid;
    pc_o          = 64'h0;
    valC_o        = 64'h0;
    valP_o        = 64'h0;
    icode_o       = 4'h0;
    ifun_o        = 4'h0;
    rA_o          = 4'hF;
    rB_o          = 4'hF;
    instr_valid_o = 1'b0;
    imem_error_o  = 1'b0;
    if (valid) begin
      pc_o          = pc_q;
      valP_o        = valp_dec;
      instr_valid_o = 1'b1;
      if (err_slot) begin
        icode_o      = 4'h1;
        imem_error_o = 1'b1;
      end else begin
        icode_o       = icode;
        ifun_o        = hb[0][3:0];
        valC_o        = valc_dec;
        instr_valid_o = icode <= 4'hB;
        if (has_regs) begin
          rA_o = hb[1][7:4];
          rB_o = hb[1][3:0];
        end
      end
    end
  end

  assign imem_req_o  = !rst_i && !outst_q && !stale_q && !stop_q && !err_pend_q &&
                       (count_q <= CW'(QUEUE_BYTES - FETCH_BYTES));
  assign imem_addr_o = faddr_q;
  assign accept      = imem_req_o && imem_ready_i;
  // stale_q can outlive outst_q across a reset, so either one claims the beat.
  assign resp        = imem_rvalid_i && (outst_q || stale_q);
  assign take_beat   = resp && !stale_q && !flush && !imem_err_i;
  assign err_beat    = resp && !stale_q && !flush && imem_err_i;
  assign off_eff     = skip_q ? skip_off_q : '0;
  assign tail        = head_q + count_q[PW-1:0];

  always_comb begin
    q_d        = q_q;
    head_d     = head_q;
    count_d    = count_q;
    pc_d       = pc_q;
    faddr_d    = faddr_q;
    outst_d    = outst_q;
    stale_d    = stale_q;
    skip_d     = skip_q;
    skip_off_d = skip_off_q;
    stop_d     = stop_q;
    err_pend_d = err_pend_q;
    widx       = '0;
    if (resp) begin
      outst_d = 1'b0;
      stale_d = 1'b0;
    end
    if (accept) begin
      outst_d = 1'b1;
      faddr_d = faddr_q + 64'(FETCH_BYTES);
    end
    if (xfer) begin
      if (!err_slot) begin
        head_d  = head_q + PW'(len);
        count_d = count_q - CW'(len);
      end
      pc_d = valp_dec;
      if (err_slot || icode == 4'h0) stop_d = 1'b1;
    end
    if (take_beat) begin
      for (int k = 0; k < FETCH_BYTES; k++) begin
        if (k >= int'(off_eff)) begin
          widx      = tail + PW'(k) - PW'(off_eff);
          q_d[widx] = imem_rdata_i[8*k +: 8];
        end
      end
      count_d = count_d + CW'(FETCH_BYTES) - CW'(off_eff);
      skip_d  = 1'b0;
    end
    if (err_beat) err_pend_d = 1'b1;
    if (flush) begin
      head_d     = '0;
      count_d    = '0;
      pc_d       = new_pc;
      faddr_d    = new_pc & ALIGN_MASK;
      skip_d     = 1'b1;
      skip_off_d = new_pc[OW-1:0];
      stop_d     = 1'b0;
      err_pend_d = 1'b0;
      stale_d    = outst_d;
    end
  end

  always_ff @(posedge clk_i) q_q <= q_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      faddr_q    <= RESET_PC & ALIGN_MASK;
      outst_q    <= 1'b0;
      stale_q    <= outst_q || stale_q;
      skip_q     <= 1'b1;
      skip_off_q <= RESET_PC[OW-1:0];
      stop_q     <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      faddr_q    <= faddr_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      skip_q     <= skip_d;
      skip_off_q <= skip_off_d;
      stop_q     <= stop_d;
      err_pend_q <= err_pend_d;
    end
  end
endmodule

// File: doc/fetch_pipe.md
# fetch_pipe

Parametrised, buffered Y86-64 fetch stage. It issues aligned multi-byte reads to instruction memory and keeps the returned bytes in a circular byte queue. It splits the queue into variable-length instructions of 1, 2, 9 or 10 bytes and hands them to decode over a valid/ready handshake. It sits between the PC/redirect logic and decode, replacing the single-cycle combinational fetch.

## Interface
- FETCH_BYTES, 8: bytes per memory beat; power of 2, 2..16.
- QUEUE_BYTES, 32: byte-queue depth; power of 2, ≥ 10+FETCH_BYTES.
- RESET_PC, 64'h0: PC loaded on reset.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- redirect_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  64  new PC, any byte alignment.
- imem_req_o  out  1  read request.
- imem_addr_o  out  64  request address, FETCH_BYTES-aligned.
- imem_ready_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response beat valid.
- imem_rdata_i  in  8*FETCH_BYTES  beat; byte k at addr+k in bits [8k+7:8k].
- imem_err_i  in  1  response error; qualified by imem_rvalid_i.
- out_valid_o  out  1  instruction available.
- out_ready_i  in  1  decode accepts.
- pc_o, valC_o, valP_o  out  64 each  instruction PC, little-endian constant, PC+length.
- icode_o, ifun_o, rA_o, rB_o  out  4 each  decoded fields.
- instr_valid_o  out  1  icode is legal (0x0..0xB).
- imem_error_o  out  1  this slot reports a memory fault.

## Operation
- Lengths by icode: 0, 1 and 9 take 1 byte; 2, 6, A and B take 2 bytes; 7 and 8 take 9 bytes; 3, 4 and 5 take 10 bytes. An illegal icode takes 1 byte and sets instr_valid_o=0.
- The register byte follows icode/ifun for lengths 2 and 10. Otherwise rA_o and rB_o are 4'hF.
- valC_o comes from bytes 2..9 (icode 3, 4, 5) or bytes 1..8 (icode 7, 8), little-endian. Otherwise it is 0.
- Request: at most one request outstanding. A request is issued when free space ≥ FETCH_BYTES and fetch is not stopped. The fetch address advances by FETCH_BYTES on each accepted request.
- First beat after a redirect or reset: bytes below the PC offset within the beat are discarded.
- Head instruction: out_valid_o=1 once the queue holds the full length implied by the head byte. The head byte alone sets the length.
- A transfer (out_valid_o & out_ready_i) pops the instruction's length in bytes and sets pc to valP.
- Halt: after icode 0 transfers, stop requesting and hold out_valid_o=0 until a redirect.
- Memory error: the errored beat is not enqueued. Once the bytes queued before the error have drained, present one slot with imem_error_o=1, icode_o=1, instr_valid_o=1, valP_o=pc_o. After that slot transfers, stop as for halt.
- Redirect: flush the queue and set pc and the fetch address. A response to a request still in flight is discarded when it returns.
- redirect_i has priority over a transfer in the same cycle. That transfer does not count; decode must squash it as well.
- Pointers wrap modulo QUEUE_BYTES. PC and valP wrap modulo 2^64.
- When out_valid_o=0, all data outputs are 0 except rA_o and rB_o, which are 4'hF.

## Timing
- Reset: out_valid_o=0, imem_req_o=0, imem_error_o=0, instr_valid_o=0, data outputs as for the invalid case, pc=RESET_PC, queue empty, outstanding flag clear.
- Request timing: first request is asserted the cycle after reset or after redirect_i. imem_req_o is held until imem_ready_i.
- Response timing: a beat on imem_rvalid_i in cycle T is enqueued at edge T. Its instruction can be valid in T+1 at the earliest.
- Decoded outputs are combinational from the queue head. They are stable while out_valid_o=1 and out_ready_i=0.
- Full queue: no request is issued. An outstanding beat always fits, guaranteed by the QUEUE_BYTES rule.
- Empty queue, or partial instruction: out_valid_o=0; no bubble fields are emitted.
- Reset mid-request: the outstanding response is discarded, as for a redirect.

## Configuration
- FETCH_PREDICT_EN defined: a transfer of icode 7 (any ifun) or 8 acts as an internal redirect to valC_o, i.e. predict taken, starting the cycle after the transfer.
- FETCH_PREDICT_EN undefined: fetch is purely sequential; all control flow changes come through redirect_i.

## Test plan
- Reset, memory holding 30 F8 08 00×7 30 F3 15 00×7 at address 0, FETCH_BYTES=8 -> two transfers: icode 3, rA F, rB 8, valC 8, valP 10; then rB 3, valC 0x15, valP 20.
- out_ready_i low for 5 cycles while out_valid_o=1 -> outputs held; no pop; requests stop when the queue is full.
- redirect_i to 0x13 while a response is outstanding -> stale beat dropped; next instruction has pc_o=0x13 and uses bytes from offset 3.
- imem_err_i on the second beat -> first instruction delivered; then imem_error_o=1 with pc_o=8; then no requests until a redirect.
- Byte 0x00 at 0x20 -> halt transferred; out_valid_o=0 and imem_req_o=0 until redirect_i.
- Byte stream 70 40 00×7, FETCH_PREDICT_EN defined -> next pc_o=0x40; macro undefined -> next pc_o=valP=9.
